// File: rtl/frame_scheduler.sv
// Multi-frame sequencer: issues one start_sys handshake per frame to the MDCT/IMDCT
// process controller, steps a wrapping buffer address, and supports abort and a watchdog.
module frame_scheduler #(
    parameter int ADDR_W    = 14,
    parameter int CNT_W     = 8,
    parameter int BUF_DEPTH = 16384,
    parameter int TMO_CYC   = 65535
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_hop,
    input  logic [CNT_W-1:0]  cfg_num_frames,
    input  logic              irq_clr,
    output logic              busy,
    output logic              done_irq,
    output logic              err_timeout,
    output logic              aborted,
    output logic [CNT_W-1:0]  frames_done,
    output logic              start_sys,
    output logic [ADDR_W-1:0] start_music_addr,
    input  logic              start_clr_sys,
    input  logic              intr_sys,
    output logic              intr_clr_sys,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_CLEAR     = 3'd3,
        S_NEXT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(BUF_DEPTH);
    localparam logic [15:0]     WD_LIMIT = 16'(TMO_CYC - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur_addr, hop_q, next_addr;
    logic [CNT_W-1:0]    num_q, frames_inc;
    logic [ADDR_W:0]     addr_sum;
    logic [15:0]         wd_cnt;
    logic                abort_pend, wd_active, wd_expired, timeout;

    assign busy             = (state != S_IDLE);
    assign start_sys        = (state == S_ISSUE);
    assign intr_clr_sys     = (state == S_CLEAR);
    assign start_music_addr = cur_addr;
    assign dbg_state        = state;
    assign frames_inc       = frames_done + CNT_W'(1);
    assign wd_active        = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_CLEAR);
    assign wd_expired       = (wd_cnt == WD_LIMIT);

    // One extra bit on the sum so base+hop cannot overflow before the wrap test.
    always_comb begin
        addr_sum  = {1'b0, cur_addr} + {1'b0, hop_q};
        next_addr = ADDR_W'((addr_sum >= DEPTH_V) ? (addr_sum - DEPTH_V) : addr_sum);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A completed handshake takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cfg_start) state_nxt = (cfg_num_frames == '0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                if (start_clr_sys)   state_nxt = S_WAIT_DONE;
                else if (wd_expired) begin timeout = 1'b1; state_nxt = S_IDLE; end
            end
            S_WAIT_DONE: begin
                if (intr_sys)        state_nxt = S_CLEAR;
                else if (wd_expired) begin timeout = 1'b1; state_nxt = S_IDLE; end
            end
            S_CLEAR: begin
                if (!intr_sys)       state_nxt = S_NEXT;
                else if (wd_expired) begin timeout = 1'b1; state_nxt = S_IDLE; end
            end
            S_NEXT: begin
                state_nxt = ((frames_inc == num_q) || abort_pend) ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            hop_q       <= '0;
            num_q       <= '0;
            frames_done <= '0;
            wd_cnt      <= '0;
            abort_pend  <= 1'b0;
            done_irq    <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            wd_cnt <= (wd_active && (state_nxt == state)) ? wd_cnt + 16'd1 : 16'd0;

            if (state == S_IDLE && cfg_start) begin
                cur_addr    <= cfg_base_addr;
                hop_q       <= cfg_hop;
                num_q       <= cfg_num_frames;
                frames_done <= '0;
                err_timeout <= 1'b0;
                aborted     <= 1'b0;
            end

            if (state == S_NEXT) begin
                frames_done <= frames_inc;
                cur_addr    <= next_addr;
            end

            if (state == S_FINISH) aborted <= abort_pend;
            if (timeout)           err_timeout <= 1'b1;

            if (state == S_FINISH || timeout || state == S_IDLE) abort_pend <= 1'b0;
            else if (cfg_abort)                                  abort_pend <= 1'b1;

            if (state == S_FINISH || timeout) done_irq <= 1'b1;
            else if (irq_clr)                 done_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a behavioural process-controller model and an
// address scoreboard fed at stimulus time and drained on each rising start_sys.
module tb_frame_scheduler;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 8;
    localparam logic [2:0] ST_ISSUE = 3'd1, ST_WAIT = 3'd2, ST_FINISH = 3'd5;

    logic              clk_in, rst_n;
    logic              cfg_start, cfg_abort, irq_clr;
    logic [ADDR_W-1:0] cfg_base_addr, cfg_hop;
    logic [CNT_W-1:0]  cfg_num_frames;
    logic              busy, done_irq, err_timeout, aborted;
    logic [CNT_W-1:0]  frames_done;
    logic              start_sys, start_clr_sys, intr_sys, intr_clr_sys;
    logic [ADDR_W-1:0] start_music_addr;
    logic [2:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W-1:0] exp_q[$];
    bit intr_en = 1'b1;

    frame_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .BUF_DEPTH(16384), .TMO_CYC(100)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_base_addr(cfg_base_addr), .cfg_hop(cfg_hop), .cfg_num_frames(cfg_num_frames),
        .irq_clr(irq_clr), .busy(busy), .done_irq(done_irq), .err_timeout(err_timeout),
        .aborted(aborted), .frames_done(frames_done), .start_sys(start_sys),
        .start_music_addr(start_music_addr), .start_clr_sys(start_clr_sys),
        .intr_sys(intr_sys), .intr_clr_sys(intr_clr_sys), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- controller model ----------------
    // Acks start_sys on its 2nd observed cycle, raises intr_sys 20 cycles later,
    // drops intr_sys once intr_clr_sys is seen.
    initial begin
        int m_state, m_cnt;
        start_clr_sys = 1'b0;
        intr_sys      = 1'b0;
        m_state = 0;
        m_cnt   = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n || !busy) begin
                start_clr_sys = 1'b0;
                intr_sys      = 1'b0;
                m_state = 0;
                m_cnt   = 0;
            end else begin
                case (m_state)
                    0: if (start_sys) begin
                        m_cnt++;
                        if (m_cnt == 2) begin start_clr_sys = 1'b1; m_state = 1; m_cnt = 0; end
                    end
                    1: begin
                        start_clr_sys = 1'b0;
                        m_cnt++;
                        if (intr_en && m_cnt == 20) begin intr_sys = 1'b1; m_state = 2; end
                    end
                    default: if (intr_clr_sys) begin intr_sys = 1'b0; m_state = 0; m_cnt = 0; end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) prev = 1'b0;
            else begin
                if (start_sys && !prev) begin
                    if (exp_q.size() == 0) check("unexpected_start_sys", 32'd1, 32'd0);
                    else                   check("frame_addr", 32'(start_music_addr), 32'(exp_q.pop_front()));
                end
                check("start_clr_exclusive", 32'(start_sys & intr_clr_sys), 32'd0);
                prev = start_sys;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] hop,
                             input logic [CNT_W-1:0] n);
        @(negedge clk_in);
        cfg_base_addr  = base;
        cfg_hop        = hop;
        cfg_num_frames = n;
        cfg_start      = 1'b1;
        @(negedge clk_in);
        cfg_start      = 1'b0;
    endtask

    task automatic pulse_irq_clr();
        @(negedge clk_in);
        irq_clr = 1'b1;
        @(negedge clk_in);
        irq_clr = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin @(negedge clk_in); n++; end
        check("run_ends", 32'(busy), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] target, input int max_cyc);
        int n = 0;
        while (dbg_state !== target && n < max_cyc) begin @(negedge clk_in); n++; end
        check("reach_state", 32'(dbg_state), 32'(target));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; irq_clr = 1'b0;
        cfg_base_addr = '0; cfg_hop = '0; cfg_num_frames = '0;
        repeat (3) @(negedge clk_in);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_irq", 32'(done_irq), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);
        check("rst_start_sys", 32'(start_sys), 32'd0);
        check("rst_addr", 32'(start_music_addr), 32'd0);
        check("rst_intr_clr", 32'(intr_clr_sys), 32'd0);
        rst_n = 1'b1;

        // three frames, linear addresses
        exp_q.push_back(14'd0); exp_q.push_back(14'd256); exp_q.push_back(14'd512);
        start_run(14'd0, 14'd256, 8'd3);
        wait_idle(500);
        check("t1_frames", 32'(frames_done), 32'd3);
        check("t1_done_irq", 32'(done_irq), 32'd1);
        check("t1_aborted", 32'(aborted), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_irq_clr();
        check("t1_irq_cleared", 32'(done_irq), 32'd0);

        // wrap at buffer depth
        exp_q.push_back(14'd16128); exp_q.push_back(14'd0);
        start_run(14'd16128, 14'd256, 8'd2);
        wait_idle(500);
        check("t2_frames", 32'(frames_done), 32'd2);
        check("t2_done_irq", 32'(done_irq), 32'd1);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_irq_clr();

        // zero-frame run
        start_run(14'd99, 14'd1, 8'd0);
        check("t3_busy_finish", 32'(busy), 32'd1);
        check("t3_irq_not_yet", 32'(done_irq), 32'd0);
        @(negedge clk_in);
        check("t3_done_irq", 32'(done_irq), 32'd1);
        check("t3_busy_low", 32'(busy), 32'd0);
        check("t3_frames", 32'(frames_done), 32'd0);
        pulse_irq_clr();

        // abort during the second frame's wait
        exp_q.push_back(14'd100); exp_q.push_back(14'd150);
        start_run(14'd100, 14'd50, 8'd5);
        wait_state(ST_WAIT, 200);
        wait_state(ST_ISSUE, 200);
        wait_state(ST_WAIT, 200);
        cfg_abort = 1'b1;
        @(negedge clk_in);
        cfg_abort = 1'b0;
        wait_idle(500);
        check("t4_frames", 32'(frames_done), 32'd2);
        check("t4_aborted", 32'(aborted), 32'd1);
        check("t4_done_irq", 32'(done_irq), 32'd1);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_irq_clr();

        // watchdog: controller never completes
        intr_en = 1'b0;
        exp_q.push_back(14'd200);
        start_run(14'd200, 14'd0, 8'd1);
        check("t5_aborted_cleared", 32'(aborted), 32'd0);
        wait_state(ST_WAIT, 50);
        cnt = 0;
        while (busy && cnt < 300) begin @(negedge clk_in); cnt++; end
        check("t5_wait_cycles", 32'(cnt), 32'd100);
        check("t5_err", 32'(err_timeout), 32'd1);
        check("t5_done_irq", 32'(done_irq), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_start_sys", 32'(start_sys), 32'd0);
        check("t5_intr_clr", 32'(intr_clr_sys), 32'd0);
        check("t5_frames", 32'(frames_done), 32'd0);
        intr_en = 1'b1;
        pulse_irq_clr();

        // cfg_start while busy is ignored
        exp_q.push_back(14'd1000); exp_q.push_back(14'd1010);
        start_run(14'd1000, 14'd10, 8'd2);
        check("t6_err_cleared", 32'(err_timeout), 32'd0);
        repeat (3) @(negedge clk_in);
        start_run(14'd5000, 14'd77, 8'd7);
        wait_idle(500);
        check("t6_frames", 32'(frames_done), 32'd2);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        pulse_irq_clr();

        // irq_clr coincident with FINISH: set wins
        exp_q.push_back(14'd7);
        start_run(14'd7, 14'd3, 8'd1);
        wait_state(ST_FINISH, 200);
        irq_clr = 1'b1;
        @(negedge clk_in);
        irq_clr = 1'b0;
        check("t6_set_wins", 32'(done_irq), 32'd1);
        pulse_irq_clr();
        check("t6_irq_clear", 32'(done_irq), 32'd0);

        // abort in IDLE is ignored
        @(negedge clk_in);
        cfg_abort = 1'b1;
        @(negedge clk_in);
        cfg_abort = 1'b0;
        exp_q.push_back(14'd20); exp_q.push_back(14'd25);
        start_run(14'd20, 14'd5, 8'd2);
        wait_idle(500);
        check("t7_frames", 32'(frames_done), 32'd2);
        check("t7_aborted", 32'(aborted), 32'd0);
        pulse_irq_clr();

        // asynchronous reset mid-ISSUE
        exp_q.push_back(14'd300);
        start_run(14'd300, 14'd1, 8'd4);
        wait_state(ST_ISSUE, 20);
        #1 rst_n = 1'b0;
        #1;
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_start_sys", 32'(start_sys), 32'd0);
        check("t8_addr", 32'(start_music_addr), 32'd0);
        check("t8_frames", 32'(frames_done), 32'd0);
        check("t8_done_irq", 32'(done_irq), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
